// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: registered MSB-first pattern shifter with start/hold/abort and a busy/last handshake.
// Define PATTERN_LOOP_EN to honour the loop input and repeat the pattern with no gap.
module serial_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  input  logic             loop,
  output logic             serial_out,
  output logic             valid,
  output logic             busy,
  output logic             last
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [LEN_W-1:0] idx, idx_n, len_q, len_n, len_c;
  logic [WIDTH-1:0] pat_q, pat_n, pat_sh;
  logic ld, lp;
`ifdef PATTERN_LOOP_EN
  assign lp = loop;
`else
  logic loop_unused;
  assign lp = 1'b0;
  assign loop_unused = loop;
`endif
  always_comb begin
    len_c = length > LEN_W'(WIDTH) ? LEN_W'(WIDTH) : length;
    ld = load && state == IDLE;
    pat_n = ld ? pattern : pat_q;
    len_n = ld ? len_c : len_q;
    state_n = state;
    idx_n = idx;
    if (state == IDLE) begin
      if (start && len_n != '0) begin
        state_n = SHIFT;
        idx_n = len_n - LEN_W'(1);
      end
    end else if (abort) state_n = IDLE;
    else if (!hold) begin
      if (idx != '0) idx_n = idx - LEN_W'(1);
      else if (lp) idx_n = len_q - LEN_W'(1);
      else state_n = IDLE;
    end
    pat_sh = pat_n >> idx_n;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      pat_q <= '0;
      len_q <= '0;
      serial_out <= 1'b0;
      valid <= 1'b0;
      busy <= 1'b0;
      last <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      pat_q <= pat_n;
      len_q <= len_n;
      serial_out <= state_n == SHIFT && pat_sh[0];
      valid <= state_n == SHIFT;
      busy <= state_n == SHIFT;
      last <= state_n == SHIFT && idx_n == '0;
    end
  end
endmodule
